mem_wb_skid_reg: RTL and testbench
==================================

Name: mem_wb_skid_reg

Overview:
- Parametrised MEM→WB pipeline boundary; replaces the fixed 32-bit free-running M/W register.
- Adds valid/ready handshake, a 2-entry skid buffer for stall tolerance, flush, and load-data extraction (byte/halfword/word, sign/zero extend).
- Adds write-back result selection (ALU / memory / PC+4), so the W stage receives a final result_W and register write controls.
- Sits between data memory read port and register file write port.

Parameters:
- XLEN, 32, datapath width (≥16, multiple of 8)
- REG_AW, 5, register-file address width
- CNT_W, 64, retire counter width (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- valid_M  in  1  M-stage beat valid
- ready_M  out  1  block can accept a beat
- flush_W  in  1  kill all held and incoming beats
- ALU_result_M  in  XLEN  ALU result / load address
- pc_plus4_M  in  XLEN  PC+4 for jal/jalr
- data_memory_RD_M  in  XLEN  raw memory read word
- register_file_WA_M  in  REG_AW  destination register
- ctrl_register_file_WE_M  in  1  register write enable
- ctrl_result_M  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
- ctrl_load_funct3_M  in  3  load type
- ready_W  in  1  W stage consumes the beat
- valid_W  out  1  output beat valid
- result_W  out  XLEN  final write-back value
- register_file_WA_W  out  REG_AW  destination register
- ctrl_register_file_WE_W  out  1  write enable, already ANDed with valid_W

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Both entries are invalid.
  - valid_W, result_W, register_file_WA_W and ctrl_register_file_WE_W are 0.
  - ready_M is driven 0 while rst_n=0, and is 1 on the first cycle after release.
  - Reset mid-stall discards all held beats.
- Load extraction is done combinationally before capture, using off = ALU_result_M[1:0]:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword at off[1], sign-extended; off[0] ignored.
  - 101 LHU: halfword at off[1], zero-extended; off[0] ignored.
  - 010, and all other codes: full word, offset ignored.
  - Little-endian: byte 0 = bits[7:0].
- Result select is also done before capture; only the selected XLEN value is stored, not the raw inputs.
- Storage: a main entry drives the outputs; a skid entry holds an overflow beat.
  - ready_M = NOT skid_valid, registered (no combinational path from ready_W to ready_M).
- Accept = valid_M & ready_M.
- Latency: a beat accepted at edge k appears on valid_W after edge k if main is empty or draining (ready_W=1); otherwise it goes to skid.
- Transitions per edge (main, skid), with no flush:
  - Empty + accept → main.
  - Main valid, ready_W=1, accept → main replaced by the new beat.
  - Main valid, ready_W=0, accept → new beat to skid; ready_M falls next cycle.
  - Skid valid, ready_W=1 → skid moves to main; skid empties.
  - Main valid, ready_W=1, no accept → main empties.
- Ordering: strictly in-order; a beat never bypasses a skid-held beat.
- No beat is dropped or duplicated unless flushed.
- flush_W=1 at an edge:
  - Both entries are invalidated, including any beat accepted in the same cycle; flush has priority.
  - Data registers may retain stale values, but ctrl_register_file_WE_W must be 0.
- When valid_W=0, the outputs result_W and register_file_WA_W are don't-care; ctrl_register_file_WE_W is 0.
- A write to register 0 passes through unchanged; the register file ignores it.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_count (CNT_W bits, reset 0).
  - Increments by 1 on every edge where valid_W & ready_W & ~flush_W.
  - Wraps modulo 2^CNT_W.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, valid_M=1 with ALU result 0x0000_1234, ctrl_result=00, WA=5, WE=1, ready_W=1 → next cycle: valid_W=1, result_W=0x0000_1234, WA_W=5, WE_W=1.
- Loads with RD=0x80FF_7F01 and ready_W=1:
  - LB off=1 → 0x0000_007F.
  - LB off=3 → 0xFFFF_FF80.
  - LBU off=3 → 0x0000_0080.
  - LH off=2 → 0xFFFF_80FF.
  - LHU off=0 → 0x0000_7F01.
  - funct3=111 → 0x80FF_7F01.
- Stall: ready_W=0, send beats A and B back-to-back → A held on the outputs, B in skid, ready_M=0 the next cycle. Then ready_W=1 → A then B on consecutive cycles, and ready_M returns to 1.
- Flush with both entries full and valid_M=1 in the same cycle → next cycle valid_W=0, WE_W=0, ready_M=1; no beat emitted afterwards.
- ctrl_result=10 with pc_plus4=0x0000_0104 → result_W=0x0000_0104.
- ctrl_result=11 with ALU result 0x55 → result_W=0x55.
- rst_n=0 during a stall with skid full → all outputs 0 and ready_M=0. With MEM_WB_RETIRE_CNT_EN defined: 3 completed beats → retire_count=3, and the count is not incremented by flushed beats.

Source files
------------

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline boundary: load extraction, result select, 2-entry skid buffer with flush.
// Optional retire counter output enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_skid_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_M,
  output logic              ready_M,
  input  logic              flush_W,
  input  logic [XLEN-1:0]   ALU_result_M,
  input  logic [XLEN-1:0]   pc_plus4_M,
  input  logic [XLEN-1:0]   data_memory_RD_M,
  input  logic [REG_AW-1:0] register_file_WA_M,
  input  logic              ctrl_register_file_WE_M,
  input  logic [1:0]        ctrl_result_M,
  input  logic [2:0]        ctrl_load_funct3_M,
  input  logic              ready_W,
  output logic              valid_W,
  output logic [XLEN-1:0]   result_W,
  output logic [REG_AW-1:0] register_file_WA_W,
  output logic              ctrl_register_file_WE_W
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_count
`endif
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_result;
  logic              w_accept;

  logic              r_main_valid, w_main_valid;
  logic [XLEN-1:0]   r_main_result, w_main_result;
  logic [REG_AW-1:0] r_main_wa, w_main_wa;
  logic              r_main_we, w_main_we;
  logic              r_skid_valid, w_skid_valid;
  logic [XLEN-1:0]   r_skid_result, w_skid_result;
  logic [REG_AW-1:0] r_skid_wa, w_skid_wa;
  logic              r_skid_we, w_skid_we;

  always_comb begin
    w_byte = data_memory_RD_M[{ALU_result_M[1:0], 3'b000} +: 8];
    w_half = data_memory_RD_M[{ALU_result_M[1], 4'b0000} +: 16];
    case (ctrl_load_funct3_M)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = data_memory_RD_M;
    endcase
    case (ctrl_result_M)
      2'b01:   w_result = w_load;
      2'b10:   w_result = pc_plus4_M;
      default: w_result = ALU_result_M;
    endcase
  end

  // ready_M depends only on the skid register, never on ready_W.
  assign ready_M  = rst_n & ~r_skid_valid;
  assign w_accept = valid_M & ready_M;

  always_comb begin
    w_main_valid  = r_main_valid;
    w_main_result = r_main_result;
    w_main_wa     = r_main_wa;
    w_main_we     = r_main_we;
    w_skid_valid  = r_skid_valid;
    w_skid_result = r_skid_result;
    w_skid_wa     = r_skid_wa;
    w_skid_we     = r_skid_we;
    if (r_skid_valid) begin
      if (ready_W) begin
        w_main_valid  = 1'b1;
        w_main_result = r_skid_result;
        w_main_wa     = r_skid_wa;
        w_main_we     = r_skid_we;
        w_skid_valid  = 1'b0;
      end
    end else if (!r_main_valid || ready_W) begin
      w_main_valid = w_accept;
      if (w_accept) begin
        w_main_result = w_result;
        w_main_wa     = register_file_WA_M;
        w_main_we     = ctrl_register_file_WE_M;
      end
    end else if (w_accept) begin
      w_skid_valid  = 1'b1;
      w_skid_result = w_result;
      w_skid_wa     = register_file_WA_M;
      w_skid_we     = ctrl_register_file_WE_M;
    end
    if (flush_W) begin
      w_main_valid = 1'b0;
      w_skid_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid  <= 1'b0;
      r_main_result <= '0;
      r_main_wa     <= '0;
      r_main_we     <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_result <= '0;
      r_skid_wa     <= '0;
      r_skid_we     <= 1'b0;
    end else begin
      r_main_valid  <= w_main_valid;
      r_main_result <= w_main_result;
      r_main_wa     <= w_main_wa;
      r_main_we     <= w_main_we;
      r_skid_valid  <= w_skid_valid;
      r_skid_result <= w_skid_result;
      r_skid_wa     <= w_skid_wa;
      r_skid_we     <= w_skid_we;
    end
  end

  assign valid_W                 = r_main_valid;
  assign result_W                = r_main_result;
  assign register_file_WA_W      = r_main_wa;
  assign ctrl_register_file_WE_W = r_main_we & r_main_valid;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (valid_W & ready_W & ~flush_W) begin
      r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign retire_count = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: driver pushes expected beats, monitor pops on handshake.
module tb_mem_wb_skid_reg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_M = 1'b0;
  logic              ready_M;
  logic              flush_W = 1'b0;
  logic [XLEN-1:0]   ALU_result_M = '0;
  logic [XLEN-1:0]   pc_plus4_M = '0;
  logic [XLEN-1:0]   data_memory_RD_M = '0;
  logic [REG_AW-1:0] register_file_WA_M = '0;
  logic              ctrl_register_file_WE_M = 1'b0;
  logic [1:0]        ctrl_result_M = '0;
  logic [2:0]        ctrl_load_funct3_M = '0;
  logic              ready_W = 1'b0;
  logic              valid_W;
  logic [XLEN-1:0]   result_W;
  logic [REG_AW-1:0] register_file_WA_W;
  logic              ctrl_register_file_WE_W;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0]  retire_count;
`endif

  mem_wb_skid_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .valid_M                 (valid_M),
    .ready_M                 (ready_M),
    .flush_W                 (flush_W),
    .ALU_result_M            (ALU_result_M),
    .pc_plus4_M              (pc_plus4_M),
    .data_memory_RD_M        (data_memory_RD_M),
    .register_file_WA_M      (register_file_WA_M),
    .ctrl_register_file_WE_M (ctrl_register_file_WE_M),
    .ctrl_result_M           (ctrl_result_M),
    .ctrl_load_funct3_M      (ctrl_load_funct3_M),
    .ready_W                 (ready_W),
    .valid_W                 (valid_W),
    .result_W                (result_W),
    .register_file_WA_W      (register_file_WA_W),
    .ctrl_register_file_WE_W (ctrl_register_file_WE_W)
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    .retire_count            (retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] wa;
    logic              we;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  longint      model_cnt = 0;
  logic [31:0] rd_word = 32'h80FF_7F01;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat retires at the next edge when valid_W & ready_W with no flush/reset.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) chk("we_implies_valid", {63'd0, ctrl_register_file_WE_W & ~valid_W}, 64'd0);
      if (rst_n && valid_W && ready_W && !flush_W) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {63'd0, valid_W}, 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("result_W", {32'd0, result_W}, {32'd0, b.result});
          chk("WA_W", {59'd0, register_file_WA_W}, {59'd0, b.wa});
          chk("WE_W", {63'd0, ctrl_register_file_WE_W}, {63'd0, b.we});
          model_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] wa,
                      input logic we, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] exp);
    bit done = 0;
    valid_M = 1'b1; ALU_result_M = alu; pc_plus4_M = pc; data_memory_RD_M = rd_word;
    register_file_WA_M = wa; ctrl_register_file_WE_M = we;
    ctrl_result_M = sel; ctrl_load_funct3_M = f3;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = ready_M;
      @(posedge clk);
      if (done) exp_q.push_back('{result: exp, wa: wa, we: we});
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    #1 valid_M = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid_W", {63'd0, valid_W}, 64'd0);
    chk("rst_result_W", {32'd0, result_W}, 64'd0);
    chk("rst_WA_W", {59'd0, register_file_WA_W}, 64'd0);
    chk("rst_WE_W", {63'd0, ctrl_register_file_WE_W}, 64'd0);
    chk("rst_ready_M", {63'd0, ready_M}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; ready_W = 1'b1;

    send(32'h0000_1234, 32'h0, 5'd5, 1'b1, 2'b00, 3'b000, 32'h0000_1234);
    @(negedge clk);
    chk("first_valid_W", {63'd0, valid_W}, 64'd1);
    @(posedge clk); #1;

    // Loads from 0x80FF_7F01 at various offsets and widths.
    send(32'h0000_1001, 32'h0, 5'd6, 1'b1, 2'b01, 3'b000, 32'h0000_007F);
    send(32'h0000_1003, 32'h0, 5'd7, 1'b1, 2'b01, 3'b000, 32'hFFFF_FF80);
    send(32'h0000_1003, 32'h0, 5'd8, 1'b1, 2'b01, 3'b100, 32'h0000_0080);
    send(32'h0000_1002, 32'h0, 5'd9, 1'b1, 2'b01, 3'b001, 32'hFFFF_80FF);
    send(32'h0000_1003, 32'h0, 5'd9, 1'b1, 2'b01, 3'b001, 32'hFFFF_80FF);
    send(32'h0000_1000, 32'h0, 5'd10, 1'b1, 2'b01, 3'b101, 32'h0000_7F01);
    send(32'h0000_1002, 32'h0, 5'd10, 1'b1, 2'b01, 3'b101, 32'h0000_80FF);
    send(32'h0000_1001, 32'h0, 5'd11, 1'b1, 2'b01, 3'b010, 32'h80FF_7F01);
    send(32'h0000_1000, 32'h0, 5'd12, 1'b1, 2'b01, 3'b111, 32'h80FF_7F01);
    send(32'h0000_2000, 32'h0000_0104, 5'd1, 1'b1, 2'b10, 3'b000, 32'h0000_0104);
    send(32'h0000_0055, 32'h0000_0104, 5'd2, 1'b0, 2'b11, 3'b000, 32'h0000_0055);
    send(32'h0000_0077, 32'h0, 5'd0, 1'b1, 2'b00, 3'b000, 32'h0000_0077);
    idle(3);

    // Stall: A held on outputs, B in skid, then drained in order.
    ready_W = 1'b0;
    send(32'h0000_00AA, 32'h0, 5'd3, 1'b1, 2'b00, 3'b000, 32'h0000_00AA);
    send(32'h0000_00BB, 32'h0, 5'd4, 1'b1, 2'b00, 3'b000, 32'h0000_00BB);
    @(negedge clk);
    chk("stall_ready_M", {63'd0, ready_M}, 64'd0);
    chk("stall_hold_A", {32'd0, result_W}, 64'h00AA);
    idle(2);
    @(negedge clk);
    chk("stall_still_A", {32'd0, result_W}, 64'h00AA);
    @(posedge clk);
    #1 ready_W = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drain_ready_M", {63'd0, ready_M}, 64'd1);
    chk("drain_B", {32'd0, result_W}, 64'h00BB);
    @(posedge clk); #1;
    idle(2);

    // Flush with both entries full and a new beat offered in the same cycle.
    ready_W = 1'b0;
    send(32'h0000_0C01, 32'h0, 5'd13, 1'b1, 2'b00, 3'b000, 32'h0000_0C01);
    send(32'h0000_0C02, 32'h0, 5'd14, 1'b1, 2'b00, 3'b000, 32'h0000_0C02);
    valid_M = 1'b1; ALU_result_M = 32'h0000_0C03; ctrl_result_M = 2'b00;
    flush_W = 1'b1;
    @(posedge clk);
    #1 flush_W = 1'b0; valid_M = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid_W", {63'd0, valid_W}, 64'd0);
    chk("flush_WE_W", {63'd0, ctrl_register_file_WE_W}, 64'd0);
    chk("flush_ready_M", {63'd0, ready_M}, 64'd1);
    @(posedge clk);
    #1 ready_W = 1'b1;
    idle(4);

`ifdef MEM_WB_RETIRE_CNT_EN
    @(negedge clk);
    chk("retire_count", retire_count, model_cnt);
    @(posedge clk); #1;
`endif

    // Reset during a stall with the skid full.
    ready_W = 1'b0;
    send(32'h0000_0D01, 32'h0, 5'd15, 1'b1, 2'b00, 3'b000, 32'h0000_0D01);
    send(32'h0000_0D02, 32'h0, 5'd16, 1'b1, 2'b00, 3'b000, 32'h0000_0D02);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    chk("midrst_valid_W", {63'd0, valid_W}, 64'd0);
    chk("midrst_result_W", {32'd0, result_W}, 64'd0);
    chk("midrst_WA_W", {59'd0, register_file_WA_W}, 64'd0);
    chk("midrst_WE_W", {63'd0, ctrl_register_file_WE_W}, 64'd0);
    chk("midrst_ready_M", {63'd0, ready_M}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; ready_W = 1'b1;
    send(32'h0000_0E01, 32'h0, 5'd17, 1'b1, 2'b00, 3'b000, 32'h0000_0E01);
    send(32'h0000_0E02, 32'h0, 5'd18, 1'b0, 2'b00, 3'b000, 32'h0000_0E02);
    send(32'h0000_0E03, 32'h0, 5'd19, 1'b1, 2'b00, 3'b000, 32'h0000_0E03);
    idle(3);

`ifdef MEM_WB_RETIRE_CNT_EN
    @(negedge clk);
    chk("retire_count_3", retire_count, 64'd3);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
